i2s_audio_rx: RTL and testbench
===============================

Name: i2s_audio_rx

Overview:
- Philips-format I2S receiver: the input-side counterpart of the core's I2S audio transmitter.
- Captures stereo PCM from an external ADC or codec (BCK/LRCK/DATA driven externally, asynchronous to the core clock).
- Delivers left/right sample pairs to the core audio path, e.g. the tape/audio-in mixer, as a one-cycle strobe in the clk_sys domain.
- Detects loss of the bit clock and malformed slot lengths.

Parameters:
- AUDIO_DW, 16, output sample width in bits; allowed range 8..32.
- TIMEOUT, 1024, clk_sys cycles without a synchronized BCK rise before lock is dropped.

Ports:
- clk_sys  in  1  core clock; must be at least 4x the BCK frequency.
- reset_n  in  1  synchronous, active-low reset.
- i2s_bck  in  1  external bit clock, asynchronous.
- i2s_lrck  in  1  external word select; 0 = left, 1 = right; asynchronous.
- i2s_data  in  1  external serial data, MSB first; asynchronous.
- sample_l  out  AUDIO_DW  last complete left sample, two's complement.
- sample_r  out  AUDIO_DW  last complete right sample, two's complement.
- sample_valid  out  1  one-cycle strobe: a new L/R pair is presented.
- frame_err  out  1  one-cycle strobe coincident with sample_valid; that pair had a slot shorter than AUDIO_DW.
- locked  out  1  high while a valid frame stream is being received.

Behaviour:
Reset (reset_n=0 at a clk_sys edge):
- Outputs: sample_l=0, sample_r=0, sample_valid=0, frame_err=0, locked=0.
- State: WAIT_SYNC, bit counter cleared, synchronizers cleared to 0.

Input synchronization:
- Each input passes through a 2-FF synchronizer, followed by a third stage on BCK for edge detection.
- Rise event = sync stage 2 is 1 and stage 3 is 0; lasts one clk_sys cycle.
- All protocol actions occur only in rise-event cycles. Outputs update at the next clk_sys edge.
- Pin-to-output latency is 4 clk_sys edges.

Per rise event (lr = synced LRCK, d = synced DATA, lr_q = LRCK captured at the previous rise):
- If lr == lr_q (mid-slot):
  - If bitcnt < AUDIO_DW, shift d into the current channel shift register at position AUDIO_DW-1-bitcnt.
  - Increment bitcnt, saturating at 63.
  - Bits beyond AUDIO_DW are discarded (long slot, no error).
- If lr != lr_q (boundary; one-bit I2S delay):
  - d is the final bit of the previous slot; store it if bitcnt < AUDIO_DW.
  - Close the previous slot: record short = (bitcnt+1 < AUDIO_DW). Unfilled LSBs are 0 (left-justified).
  - Reset bitcnt to 0.

State machine:
- WAIT_SYNC: ignore data. On a boundary with lr 1->0 (left slot begins) -> LEFT.
- LEFT: on a boundary 0->1, latch the left shift register into an internal holding register, save the short flag -> RIGHT.
- RIGHT: on a boundary 1->0:
  - Load sample_l from the holding register and sample_r from the right shift register.
  - sample_valid=1 for exactly one cycle; frame_err=1 if either slot was short; locked=1.
  - Next state: LEFT.
- Shift registers are cleared at every slot start.

Timeout:
- A counter clears on every rise event and increments otherwise.
- On reaching TIMEOUT: locked=0, state -> WAIT_SYNC, partial frame discarded.
- sample_l/sample_r hold their last values; no strobe is emitted.

Boundary conditions:
- Reset mid-frame: the partial frame is discarded; the first strobe comes only after a full L then R pair.
- A lone right slot after sync produces no output.
- sample_valid never asserts in two consecutive cycles.
- Asserting reset_n in the same cycle as a completing rise: reset wins, no strobe.
- LRCK toggling on consecutive rises (1-bit slot): treated as a short slot; frame_err set on that pair.

Test Plan:
1. Reset, then 32-bit-slot stereo frames L=0x1234, R=0xFEDC (DW=16), BCK = clk_sys/8 -> first frame after sync gives sample_valid once, sample_l=0x1234, sample_r=0xFEDC, frame_err=0, locked=1; exactly 4 clk_sys edges after the pin BCK rise carrying the boundary.
2. 16-bit slots L=0x8000, R=0x7FFF -> exact capture (one-bit delay honoured, LSB taken at the boundary rise); 0x8000 stays negative.
3. 12-bit slots L=0xABC, R=0x123 -> sample_l=0xABC0, sample_r=0x1230, frame_err=1 with the strobe.
4. Stop BCK for TIMEOUT+1 cycles after a good frame -> locked=0 on cycle TIMEOUT; outputs hold; BCK resumes -> first strobe only after a full L+R pair.
5. reset_n low for one cycle in the middle of a right slot -> outputs 0, no strobe for that frame; next complete pair captured correctly.
6. Stream starts inside a right slot (LRCK=1 at first rise) -> no strobe until after the following left and right slots.

Source files
------------

// File: rtl/i2s_audio_rx.sv
// Philips-format I2S receiver: synchronizes external BCK/LRCK/DATA into clk_sys,
// assembles left/right slots and presents each completed pair as a one-cycle strobe.
module i2s_audio_rx #(
    parameter int AUDIO_DW = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                i2s_bck,
    input  logic                i2s_lrck,
    input  logic                i2s_data,
    output logic [AUDIO_DW-1:0] sample_l,
    output logic [AUDIO_DW-1:0] sample_r,
    output logic                sample_valid,
    output logic                frame_err,
    output logic                locked
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    // Strobe semantics: sample_valid is high for exactly one clk_sys cycle per pair;
    // there is no back-pressure, and sample_l/sample_r stay stable until the next strobe.

    logic [2:0]          bck_sync;
    logic [1:0]          lr_sync;
    logic [1:0]          d_sync;
    logic                rise;
    logic                lr;
    logic                d;
    logic                boundary;

    state_t              state, state_n;
    logic                lr_q, lr_q_n;
    logic [5:0]          bitcnt, bitcnt_n;
    logic [AUDIO_DW-1:0] shreg, shreg_n;
    logic [AUDIO_DW-1:0] hold_l, hold_l_n;
    logic                short_l, short_l_n;
    logic [AUDIO_DW-1:0] sample_l_n, sample_r_n;
    logic                valid_n, err_n, locked_n;
    logic [TW-1:0]       tcnt;

    logic [5:0]          pos;
    logic [AUDIO_DW-1:0] bit_word;
    logic [AUDIO_DW-1:0] slot_word;
    logic [6:0]          cnt_plus;
    logic                slot_short;

    assign rise     = bck_sync[1] & ~bck_sync[2];
    assign lr       = lr_sync[1];
    assign d        = d_sync[1];
    assign boundary = (lr != lr_q);

    // Slot contents including the bit on the current rise, left-justified.
    assign pos        = 6'(AUDIO_DW - 1) - bitcnt;
    assign bit_word   = {{(AUDIO_DW-1){1'b0}}, d} << pos;
    assign slot_word  = (bitcnt < 6'(AUDIO_DW)) ? (shreg | bit_word) : shreg;
    assign cnt_plus   = {1'b0, bitcnt} + 7'd1;
    assign slot_short = (cnt_plus < 7'(AUDIO_DW));

    always_comb begin
        state_n    = state;
        lr_q_n     = lr_q;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        hold_l_n   = hold_l;
        short_l_n  = short_l;
        sample_l_n = sample_l;
        sample_r_n = sample_r;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        locked_n   = locked;

        if (rise) begin
            lr_q_n = lr;
            if (!boundary) begin
                shreg_n = slot_word;
                if (bitcnt != 6'd63) begin
                    bitcnt_n = bitcnt + 6'd1;
                end
            end else begin
                // The boundary rise carries the last bit of the slot that just ended.
                bitcnt_n = '0;
                shreg_n  = '0;
                case (state)
                    WAIT_SYNC: begin
                        if (!lr) begin
                            state_n = LEFT;
                        end
                    end
                    LEFT: begin
                        if (lr) begin
                            hold_l_n  = slot_word;
                            short_l_n = slot_short;
                            state_n   = RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (!lr) begin
                            sample_l_n = hold_l;
                            sample_r_n = slot_word;
                            valid_n    = 1'b1;
                            err_n      = short_l | slot_short;
                            locked_n   = 1'b1;
                            state_n    = LEFT;
                        end
                    end
                    default: state_n = WAIT_SYNC;
                endcase
            end
        end else if (tcnt == TW'(TIMEOUT)) begin
            locked_n = 1'b0;
            state_n  = WAIT_SYNC;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bck_sync     <= '0;
            lr_sync      <= '0;
            d_sync       <= '0;
            state        <= WAIT_SYNC;
            lr_q         <= 1'b0;
            bitcnt       <= '0;
            shreg        <= '0;
            hold_l       <= '0;
            short_l      <= 1'b0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
            tcnt         <= '0;
        end else begin
            bck_sync     <= {bck_sync[1:0], i2s_bck};
            lr_sync      <= {lr_sync[0], i2s_lrck};
            d_sync       <= {d_sync[0], i2s_data};
            state        <= state_n;
            lr_q         <= lr_q_n;
            bitcnt       <= bitcnt_n;
            shreg        <= shreg_n;
            hold_l       <= hold_l_n;
            short_l      <= short_l_n;
            sample_l     <= sample_l_n;
            sample_r     <= sample_r_n;
            sample_valid <= valid_n;
            frame_err    <= err_n;
            locked       <= locked_n;
            if (rise) begin
                tcnt <= '0;
            end else if (tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: drives I2S slot streams (BCK = clk_sys/8) and compares
// every strobed pair against expectations derived from the slot list itself.
module tb_i2s_audio_rx;
    localparam int DW = 16;
    localparam int TO = 64;

    logic          clk_sys  = 1'b0;
    logic          reset_n  = 1'b0;
    logic          i2s_bck  = 1'b0;
    logic          i2s_lrck = 1'b0;
    logic          i2s_data = 1'b0;
    logic [DW-1:0] sample_l;
    logic [DW-1:0] sample_r;
    logic          sample_valid;
    logic          frame_err;
    logic          locked;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    i2s_audio_rx #(.AUDIO_DW(DW), .TIMEOUT(TO)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Slot list of the current burst and the scoreboard of expected {err, l, r}.
    int            slot_len[$];
    logic [63:0]   slot_val[$];
    logic          slot_ch[$];
    logic [2*DW:0] exp_q[$];
    int            rise_cyc[$];
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;

    int            valid_cyc  = -1;
    int            strobes    = 0;
    logic          prev_valid = 1'b0;
    logic [2*DW:0] mon_exp;

    always @(negedge clk_sys) begin
        if (sample_valid === 1'b1) begin
            valid_cyc = cyc;
            strobes++;
            checks++;
            assert (prev_valid === 1'b0) else begin
                errors++;
                $error("FAIL strobe_gap: sample_valid observed high twice in a row, required single-cycle");
            end
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_strobe: observed l=%h r=%h err=%0b, required no strobe",
                       sample_l, sample_r, frame_err);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert ({frame_err, sample_l, sample_r} === mon_exp) else begin
                    errors++;
                    $error("FAIL pair: observed err=%0b l=%h r=%h, required err=%0b l=%h r=%h",
                           frame_err, sample_l, sample_r,
                           mon_exp[2*DW], mon_exp[2*DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
        if (frame_err === 1'b1) begin
            checks++;
            assert (sample_valid === 1'b1) else begin
                errors++;
                $error("FAIL err_alone: frame_err observed without sample_valid");
            end
        end
        prev_valid = sample_valid;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic reset_dut();
        reset_n  = 1'b0;
        i2s_bck  = 1'b0;
        i2s_lrck = 1'b0;
        i2s_data = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic clear_slots();
        slot_len.delete();
        slot_val.delete();
        slot_ch.delete();
    endtask

    task automatic add_slot(input logic ch, input int len, input logic [63:0] val);
        logic [63:0] v;
        v = val;
        if (len < 64) v = v & ((64'd1 << len) - 64'd1);
        slot_ch.push_back(ch);
        slot_len.push_back(len);
        slot_val.push_back(v);
    endtask

    // A slot is received MSB first and left-justified into DW bits: surplus bits
    // are dropped, missing LSBs read as zero.
    function automatic logic [DW-1:0] exp_word(input int len, input logic [63:0] val);
        logic [63:0] w;
        if (len >= DW) w = val >> (len - DW);
        else           w = val << (DW - len);
        return w[DW-1:0];
    endfunction

    // A pair (left slot i, right slot i+1) is delivered when slot i was entered
    // from a right slot (that is the sync point), slot i+2 starts, and no reset
    // landed inside slot i or i+1.
    task automatic expect_pairs(input int k_reset);
        int n;
        logic [DW-1:0] l, r;
        logic e;
        n = slot_len.size();
        for (int i = 1; i + 2 < n; i++) begin
            if (slot_ch[i] == 1'b0 && slot_ch[i-1] == 1'b1 && slot_ch[i+1] == 1'b1 &&
                k_reset != i && k_reset != i + 1) begin
                l = exp_word(slot_len[i], slot_val[i]);
                r = exp_word(slot_len[i+1], slot_val[i+1]);
                e = (slot_len[i] < DW) || (slot_len[i+1] < DW);
                exp_q.push_back({e, l, r});
                last_l = l;
                last_r = r;
            end
        end
    endtask

    // Philips timing: LRCK changes one BCK period ahead of each word's MSB.
    task automatic drive_burst(input int k_reset, input int reset_period);
        logic dbits[$];
        logic lrbits[$];
        int   n;
        expect_pairs(k_reset);
        rise_cyc.delete();
        for (int s = 0; s < slot_len.size(); s++) begin
            for (int b = slot_len[s] - 1; b >= 0; b--) begin
                dbits.push_back(slot_val[s][b[5:0]]);
                lrbits.push_back(slot_ch[s]);
            end
        end
        n = dbits.size();
        tick(1);
        for (int t = 0; t < n; t++) begin
            i2s_bck  = 1'b0;
            i2s_data = dbits[t];
            i2s_lrck = (t + 1 < n) ? lrbits[t+1] : lrbits[n-1];
            if (t == reset_period) begin
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
                check("reset_sample_l", 64'(sample_l), 64'd0);
                check("reset_sample_r", 64'(sample_r), 64'd0);
                check("reset_locked", 64'(locked), 64'd0);
                tick(3);
            end else begin
                tick(4);
            end
            i2s_bck = 1'b1;
            rise_cyc.push_back(cyc);
            tick(4);
        end
        i2s_bck = 1'b0;
        tick(8);
    endtask

    initial begin
        int s0, lt, target, n;
        logic ch;

        // Reset state
        reset_dut();
        check("rst_sample_l", 64'(sample_l), 64'd0);
        check("rst_sample_r", 64'(sample_r), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);

        // 32-bit slots; one pair after sync, 4 edges counting the launching edge
        clear_slots();
        add_slot(1'b0, 32, 64'h1234_0000);
        add_slot(1'b1, 32, 64'hFEDC_0000);
        add_slot(1'b0, 32, 64'h1234_0000);
        add_slot(1'b1, 32, 64'hFEDC_0000);
        add_slot(1'b0, 32, 64'h0);
        s0 = strobes;
        drive_burst(-1, -1);
        check("t1_strobe_count", 64'(strobes - s0), 64'd1);
        check("t1_latency", 64'(valid_cyc - rise_cyc[127]), 64'd3);
        check("t1_sample_l", 64'(sample_l), 64'h1234);
        check("t1_sample_r", 64'(sample_r), 64'hFEDC);
        check("t1_locked", 64'(locked), 64'd1);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // BCK stops: lock must drop once TIMEOUT idle cycles have elapsed
        lt = rise_cyc[rise_cyc.size() - 1];
        target = lt + TO;
        while (cyc < target) tick(1);
        check("t4_locked_before", 64'(locked), 64'd1);
        target = lt + TO + 6;
        while (cyc < target) tick(1);
        check("t4_locked_after", 64'(locked), 64'd0);
        check("t4_hold_l", 64'(sample_l), 64'h1234);
        check("t4_hold_r", 64'(sample_r), 64'hFEDC);
        clear_slots();
        add_slot(1'b1, 20, {$urandom, $urandom});
        add_slot(1'b0, 20, {$urandom, $urandom});
        add_slot(1'b1, 20, {$urandom, $urandom});
        add_slot(1'b0, 20, {$urandom, $urandom});
        s0 = strobes;
        drive_burst(-1, -1);
        check("t4_resume_count", 64'(strobes - s0), 64'd1);
        check("t4_locked_again", 64'(locked), 64'd1);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // 16-bit slots: exact fill, LSB taken on the boundary rise
        reset_dut();
        clear_slots();
        add_slot(1'b0, 16, 64'h1111);
        add_slot(1'b1, 16, 64'h2222);
        add_slot(1'b0, 16, 64'h8000);
        add_slot(1'b1, 16, 64'h7FFF);
        add_slot(1'b0, 16, 64'h0);
        drive_burst(-1, -1);
        check("t2_sample_l", 64'(sample_l), 64'h8000);
        check("t2_sample_r", 64'(sample_r), 64'h7FFF);
        check("t2_negative", 64'(sample_l[DW-1]), 64'd1);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 12-bit slots: left-justified, frame_err flagged
        reset_dut();
        clear_slots();
        add_slot(1'b0, 12, 64'h555);
        add_slot(1'b1, 12, 64'hAAA);
        add_slot(1'b0, 12, 64'hABC);
        add_slot(1'b1, 12, 64'h123);
        add_slot(1'b0, 12, 64'h0);
        drive_burst(-1, -1);
        check("t3_sample_l", 64'(sample_l), 64'hABC0);
        check("t3_sample_r", 64'(sample_r), 64'h1230);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // One-cycle reset in the middle of a right slot
        reset_dut();
        clear_slots();
        for (int i = 0; i < 9; i++) add_slot(i[0], 32, {$urandom, $urandom});
        s0 = strobes;
        drive_burst(5, 5 * 32 + 16);
        check("t5_strobe_count", 64'(strobes - s0), 64'd2);
        check("t5_sample_l", 64'(sample_l), 64'(last_l));
        check("t5_sample_r", 64'(sample_r), 64'(last_r));
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // Stream starts inside a right slot
        reset_dut();
        clear_slots();
        add_slot(1'b1, 24, {$urandom, $urandom});
        add_slot(1'b0, 24, {$urandom, $urandom});
        add_slot(1'b1, 24, {$urandom, $urandom});
        add_slot(1'b0, 24, {$urandom, $urandom});
        s0 = strobes;
        drive_burst(-1, -1);
        check("t6_strobe_count", 64'(strobes - s0), 64'd1);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random slot lengths (1..40 bits) and contents
        for (int it = 0; it < 6; it++) begin
            reset_dut();
            clear_slots();
            n  = $urandom_range(6, 9);
            ch = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if (i == 0)                 lt = $urandom_range(2, 40);
                else if (it == 0 && i == 2) lt = 1;
                else                        lt = $urandom_range(1, 40);
                add_slot(ch, lt, {$urandom, $urandom});
                ch = ~ch;
            end
            drive_burst(-1, -1);
            check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
